// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: mem_ctrl_signal bit positions,
// access-size codes and the SRAM access FSM states.
package data_mem_responder_pkg;

  localparam int MEM_CTRL_READ  = 4;
  localparam int MEM_CTRL_WRITE = 3;
  localparam int MEM_CTRL_SIGN  = 2;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } mem_state_t;

  function automatic logic is_req(input logic [4:0] ctrl);
    return ctrl[MEM_CTRL_READ] | ctrl[MEM_CTRL_WRITE];
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory port: request from cpu_core (master), result/stall from the responder (slave).
interface data_mem_responder_if;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_ctrl_signal;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_misalign;

  modport master (
    output mem_addr, mem_wdata, mem_ctrl_signal,
    input  mem_rdata, mem_stall, mem_misalign
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_ctrl_signal,
    output mem_rdata, mem_stall, mem_misalign
  );

endinterface

// File: rtl/data_mem_responder_lane_align.sv
// Combinational little-endian lane logic: byte enables, store-data replication,
// load extraction with sign/zero extension, and misalignment detection.
module data_mem_responder_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be_n,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane   = rdata_raw[{addr_lo, 3'b000} +: 8];
    half_lane   = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    be_n        = 4'h0;
    wdata_lanes = wdata;
    rdata_ext   = rdata_raw;
    misalign    = 1'b0;
    case (size)
      MEM_SIZE_B: begin
        be_n        = ~(4'b0001 << addr_lo);
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      end
      MEM_SIZE_H: begin
        be_n        = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{sign_ext & half_lane[15]}}, half_lane};
        misalign    = addr_lo[0];
      end
      // MEM_SIZE_W and the spare 2'b11 code are both full-word accesses
      default: begin
        be_n        = 4'h0;
        wdata_lanes = wdata;
        rdata_ext   = rdata_raw;
        misalign    = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Serves one cpu_core load/store at a time as a multi-cycle async-SRAM access,
// stalling the pipeline from the request cycle until the access completes.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int SRAM_AW     = 20,
  parameter int WAIT_CYCLES = 1
)
(
  input  logic               clk_50M,
  input  logic               reset_btn,
  data_mem_responder_if.slave cpu,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_data_o,
  input  logic [31:0]        sram_data_i,
  output logic               sram_data_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);

  mem_state_t           state_q, state_d;
  logic [CW-1:0]        wait_q, wait_d;
  logic [SRAM_AW+1:0]   addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [4:0]           ctrl_q, ctrl_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
  logic [31:0]          data_o_q, data_o_d;
  logic                 data_oe_q, data_oe_d;
  logic                 ce_n_q, ce_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 we_n_q, we_n_d;
  logic [3:0]           be_n_q, be_n_d;

  logic [SRAM_AW+1:0]   eff_addr;
  logic [31:0]          eff_wdata;
  logic [4:0]           eff_ctrl;
  logic                 eff_write, eff_read;
  logic                 req_in, take;
  logic [3:0]           lane_be_n;
  logic [31:0]          lane_wdata, lane_rdata;
  logic                 lane_misalign;
  logic                 unused_addr_hi;

  assign unused_addr_hi = ^cpu.mem_addr[31:SRAM_AW+2];

  // In IDLE the lane logic looks at the live request; afterwards at the latched one.
  assign eff_addr  = (state_q == ST_IDLE) ? cpu.mem_addr[SRAM_AW+1:0] : addr_q;
  assign eff_wdata = (state_q == ST_IDLE) ? cpu.mem_wdata : wdata_q;
  assign eff_ctrl  = (state_q == ST_IDLE) ? cpu.mem_ctrl_signal : ctrl_q;
  assign eff_write = eff_ctrl[MEM_CTRL_WRITE];
  assign eff_read  = eff_ctrl[MEM_CTRL_READ] & ~eff_ctrl[MEM_CTRL_WRITE];

  assign req_in = is_req(cpu.mem_ctrl_signal);
  assign take   = (state_q == ST_IDLE) && req_in && !lane_misalign;

  data_mem_responder_lane_align u_lane_align (
    .addr_lo     (eff_addr[1:0]),
    .size        (eff_ctrl[1:0]),
    .sign_ext    (eff_ctrl[MEM_CTRL_SIGN]),
    .wdata       (eff_wdata),
    .rdata_raw   (sram_data_i),
    .be_n        (lane_be_n),
    .wdata_lanes (lane_wdata),
    .rdata_ext   (lane_rdata),
    .misalign    (lane_misalign)
  );

  always_ff @(posedge clk_50M or posedge reset_btn) begin
    if (reset_btn) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ctrl_q      <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      data_o_q    <= '0;
      data_oe_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 4'hF;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ctrl_q      <= ctrl_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      data_o_q    <= data_o_d;
      data_oe_q   <= data_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ctrl_d      = ctrl_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    data_o_d    = data_o_q;
    data_oe_d   = 1'b0;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    be_n_d      = 4'hF;

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_SETUP;
          addr_d  = cpu.mem_addr[SRAM_AW+1:0];
          wdata_d = cpu.mem_wdata;
          ctrl_d  = cpu.mem_ctrl_signal;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        wait_d  = '0;
      end
      ST_ACCESS: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_DONE;
          if (eff_read) rdata_d = lane_rdata;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pads are registered, so they are computed for the state being entered.
    if (state_d == ST_SETUP || state_d == ST_ACCESS) begin
      ce_n_d      = 1'b0;
      be_n_d      = lane_be_n;
      sram_addr_d = eff_addr[SRAM_AW+1:2];
      data_o_d    = lane_wdata;
      data_oe_d   = eff_write;
      oe_n_d      = ~eff_read;
      we_n_d      = ~((state_d == ST_ACCESS) && eff_write);
    end
  end

  assign cpu.mem_rdata    = rdata_q;
  assign cpu.mem_stall    = !reset_btn &&
                            (take || state_q == ST_SETUP || state_q == ST_ACCESS);
  assign cpu.mem_misalign = !reset_btn && (state_q == ST_IDLE) && req_in && lane_misalign;

  assign sram_addr    = sram_addr_q;
  assign sram_data_o  = data_o_q;
  assign sram_data_oe = data_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_be_n    = be_n_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a behavioural async-SRAM model (WAIT_CYCLES=1).
module tb_data_mem_responder;

  logic        clk_50M;
  logic        reset_btn;
  logic [19:0] sram_addr;
  logic [31:0] sram_data_o;
  logic [31:0] sram_data_i;
  logic        sram_data_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  data_mem_responder_if ifc ();

  data_mem_responder #(.SRAM_AW(20), .WAIT_CYCLES(1)) dut (
    .clk_50M      (clk_50M),
    .reset_btn    (reset_btn),
    .cpu          (ifc),
    .sram_addr    (sram_addr),
    .sram_data_o  (sram_data_o),
    .sram_data_i  (sram_data_i),
    .sram_data_oe (sram_data_oe),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .sram_be_n    (sram_be_n)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  // Async SRAM model: combinational read, byte-masked write while we_n is low.
  logic [31:0] sram_mem [0:255];
  assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[7:0]] : 32'h0;
  always @(posedge clk_50M) begin
    if (!sram_ce_n && !sram_we_n && sram_data_oe) begin
      for (int k = 0; k < 4; k++)
        if (!sram_be_n[k]) sram_mem[sram_addr[7:0]][8*k +: 8] <= sram_data_o[8*k +: 8];
    end
  end

  typedef struct {
    string       name;
    logic [4:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be_n;
    logic [31:0] exp_sram_addr;
    logic [31:0] exp_data_o;
    int          exp_stall;
    int          exp_we;
    logic        exp_misalign;
  } vec_t;

  vec_t vecs[$];

  int          tests_run;
  int          tests_failed;
  int          stall_cycles;
  int          we_cycles;
  logic        ce_seen;
  logic        mis_seen;
  logic        timed_out;
  logic [3:0]  be_seen;
  logic [31:0] addr_seen;
  logic [31:0] data_seen;
  logic [31:0] rdata_seen;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called just after a rising edge in IDLE; returns just after the edge that ends DONE
  // (or the misaligned request cycle) with the request still driven.
  task automatic apply_stimulus(input logic [4:0] ctrl, input logic [31:0] addr,
                                input logic [31:0] wdata);
    logic done;
    ifc.mem_ctrl_signal = ctrl;
    ifc.mem_addr        = addr;
    ifc.mem_wdata       = wdata;
    stall_cycles = 0;
    we_cycles    = 0;
    ce_seen      = 1'b0;
    mis_seen     = 1'b0;
    be_seen      = 4'hF;
    addr_seen    = 32'h0;
    data_seen    = 32'h0;
    rdata_seen   = 32'h0;
    done         = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_50M);
      if (ifc.mem_stall) stall_cycles++;
      if (ifc.mem_misalign) mis_seen = 1'b1;
      if (!sram_we_n) begin
        we_cycles++;
        data_seen = sram_data_o;
      end
      if (!sram_ce_n) begin
        ce_seen   = 1'b1;
        be_seen   = sram_be_n;
        addr_seen = 32'(sram_addr);
      end
      if (!ifc.mem_stall) begin
        rdata_seen = ifc.mem_rdata;
        done = 1'b1;
        break;
      end
    end
    timed_out = !done;
    @(posedge clk_50M);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs.push_back('{"sw_100",   5'b01010, 32'h100, 32'hDEADBEEF, 32'h00000000, 4'b0000, 32'h40, 32'hDEADBEEF, 3, 1, 1'b0});
    vecs.push_back('{"lw_100",   5'b10010, 32'h100, 32'h0,        32'hDEADBEEF, 4'b0000, 32'h40, 32'h0,        3, 0, 1'b0});
    vecs.push_back('{"sb_103",   5'b01000, 32'h103, 32'h12345680, 32'hDEADBEEF, 4'b0111, 32'h40, 32'h80808080, 3, 1, 1'b0});
    vecs.push_back('{"lb_103",   5'b10100, 32'h103, 32'h0,        32'hFFFFFF80, 4'b0111, 32'h40, 32'h0,        3, 0, 1'b0});
    vecs.push_back('{"lbu_103",  5'b10000, 32'h103, 32'h0,        32'h00000080, 4'b0111, 32'h40, 32'h0,        3, 0, 1'b0});
    vecs.push_back('{"sh_102",   5'b01001, 32'h102, 32'hABCD8001, 32'h00000080, 4'b0011, 32'h40, 32'h80018001, 3, 1, 1'b0});
    vecs.push_back('{"lh_102",   5'b10101, 32'h102, 32'h0,        32'hFFFF8001, 4'b0011, 32'h40, 32'h0,        3, 0, 1'b0});
    vecs.push_back('{"lhu_102",  5'b10001, 32'h102, 32'h0,        32'h00008001, 4'b0011, 32'h40, 32'h0,        3, 0, 1'b0});
    vecs.push_back('{"lw_100b",  5'b10010, 32'h100, 32'h0,        32'h8001BEEF, 4'b0000, 32'h40, 32'h0,        3, 0, 1'b0});
    vecs.push_back('{"lw11_100", 5'b10011, 32'h100, 32'h0,        32'h8001BEEF, 4'b0000, 32'h40, 32'h0,        3, 0, 1'b0});
    vecs.push_back('{"lb_101",   5'b10100, 32'h101, 32'h0,        32'hFFFFFFBE, 4'b1101, 32'h40, 32'h0,        3, 0, 1'b0});
    vecs.push_back('{"lhu_100",  5'b10001, 32'h100, 32'h0,        32'h0000BEEF, 4'b1100, 32'h40, 32'h0,        3, 0, 1'b0});
    vecs.push_back('{"lw_102m",  5'b10010, 32'h102, 32'h0,        32'h0000BEEF, 4'b1111, 32'h0,  32'h0,        0, 0, 1'b1});
    vecs.push_back('{"lh_101m",  5'b10101, 32'h101, 32'h0,        32'h0000BEEF, 4'b1111, 32'h0,  32'h0,        0, 0, 1'b1});
    vecs.push_back('{"rw_104",   5'b11010, 32'h104, 32'h12345678, 32'h0000BEEF, 4'b0000, 32'h41, 32'h12345678, 3, 1, 1'b0});
    vecs.push_back('{"lw_104",   5'b10010, 32'h104, 32'h0,        32'h12345678, 4'b0000, 32'h41, 32'h0,        3, 0, 1'b0});
    vecs.push_back('{"sw_000",   5'b01010, 32'h000, 32'hA5A50001, 32'h12345678, 4'b0000, 32'h00, 32'hA5A50001, 3, 1, 1'b0});
    vecs.push_back('{"sw_004",   5'b01010, 32'h004, 32'h5A5A0002, 32'h12345678, 4'b0000, 32'h01, 32'h5A5A0002, 3, 1, 1'b0});

    // Reset state, with a load request driven to show the stall is held off.
    reset_btn           = 1'b1;
    ifc.mem_ctrl_signal = 5'b10010;
    ifc.mem_addr        = 32'h100;
    ifc.mem_wdata       = 32'h0;
    repeat (2) @(negedge clk_50M);
    check_output("rst_ce_n",     32'(sram_ce_n),        32'h1);
    check_output("rst_oe_n",     32'(sram_oe_n),        32'h1);
    check_output("rst_we_n",     32'(sram_we_n),        32'h1);
    check_output("rst_be_n",     32'(sram_be_n),        32'hF);
    check_output("rst_data_oe",  32'(sram_data_oe),     32'h0);
    check_output("rst_addr",     32'(sram_addr),        32'h0);
    check_output("rst_rdata",    ifc.mem_rdata,         32'h0);
    check_output("rst_stall",    32'(ifc.mem_stall),    32'h0);
    check_output("rst_misalign", 32'(ifc.mem_misalign), 32'h0);
    ifc.mem_ctrl_signal = 5'b00000;
    reset_btn = 1'b0;
    @(posedge clk_50M);
    #1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].ctrl, vecs[i].addr, vecs[i].wdata);
      ifc.mem_ctrl_signal = 5'b00000;
      check_output({vecs[i].name, "/timeout"},  32'(timed_out),    32'h0);
      check_output({vecs[i].name, "/stall"},    32'(stall_cycles), 32'(vecs[i].exp_stall));
      check_output({vecs[i].name, "/we"},       32'(we_cycles),    32'(vecs[i].exp_we));
      check_output({vecs[i].name, "/ce"},       32'(ce_seen),      32'(vecs[i].exp_stall != 0));
      check_output({vecs[i].name, "/be_n"},     32'(be_seen),      32'(vecs[i].exp_be_n));
      check_output({vecs[i].name, "/addr"},     addr_seen,         vecs[i].exp_sram_addr);
      check_output({vecs[i].name, "/data_o"},   data_seen,         vecs[i].exp_data_o);
      check_output({vecs[i].name, "/misalign"}, 32'(mis_seen),     32'(vecs[i].exp_misalign));
      check_output({vecs[i].name, "/rdata"},    rdata_seen,        vecs[i].exp_rdata);
      @(posedge clk_50M);
      #1;
    end

    // Back-to-back loads held by a stalled CPU: second request appears right after DONE.
    apply_stimulus(5'b10010, 32'h000, 32'h0);
    check_output("b2b0_timeout", 32'(timed_out),    32'h0);
    check_output("b2b0_stall",   32'(stall_cycles), 32'd3);
    check_output("b2b0_rdata",   rdata_seen,        32'hA5A50001);
    apply_stimulus(5'b10010, 32'h004, 32'h0);
    check_output("b2b1_timeout", 32'(timed_out),    32'h0);
    check_output("b2b1_stall",   32'(stall_cycles), 32'd3);
    check_output("b2b1_rdata",   rdata_seen,        32'h5A5A0002);
    ifc.mem_ctrl_signal = 5'b00000;
    @(posedge clk_50M);
    #1;

    // Reset in the middle of a store's ACCESS cycle must abandon the write.
    apply_stimulus(5'b01010, 32'h200, 32'hCAFEF00D);
    ifc.mem_ctrl_signal = 5'b00000;
    check_output("pre_sw_stall", 32'(stall_cycles), 32'd3);
    @(posedge clk_50M);
    #1;
    ifc.mem_ctrl_signal = 5'b01010;
    ifc.mem_addr        = 32'h200;
    ifc.mem_wdata       = 32'h11111111;
    @(posedge clk_50M);
    #1;
    @(posedge clk_50M);
    #1;
    check_output("acc_we_n",    32'(sram_we_n),     32'h0);
    check_output("acc_stall",   32'(ifc.mem_stall), 32'h1);
    reset_btn = 1'b1;
    #1;
    check_output("arst_we_n",    32'(sram_we_n),     32'h1);
    check_output("arst_data_oe", 32'(sram_data_oe),  32'h0);
    check_output("arst_ce_n",    32'(sram_ce_n),     32'h1);
    check_output("arst_stall",   32'(ifc.mem_stall), 32'h0);
    check_output("arst_rdata",   ifc.mem_rdata,      32'h0);
    ifc.mem_ctrl_signal = 5'b00000;
    @(negedge clk_50M);
    reset_btn = 1'b0;
    @(posedge clk_50M);
    #1;
    apply_stimulus(5'b10010, 32'h200, 32'h0);
    ifc.mem_ctrl_signal = 5'b00000;
    check_output("post_rst_timeout", 32'(timed_out),    32'h0);
    check_output("post_rst_stall",   32'(stall_cycles), 32'd3);
    check_output("post_rst_rdata",   rdata_seen,        32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
